mc_control_fsm: RTL and testbench

Multi-cycle main control unit for the MIPS datapath. It is the producer side of the ALUOp interface: it decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and write-back cycles. It drives every datapath enable, and the ALUOp code consumed by the ALU control decoder. Memory accesses stall on a ready handshake, and retired instructions are counted.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/mc_retire_counter.sv | 30 +++
 rtl/mc_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, ALUOp/ALUSrcB/PCSource encodings and the
// multi-cycle control state enumeration. MC_CTRL_ADDI_EN adds addi to the supported set.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_CTRL_ADDI_EN
         OP_ADDI: ok = 1'b1;
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // States whose exit back to FETCH completes an instruction.
   function automatic logic is_retire_state(input state_e s);
      logic r;
      r = 1'b0;
      case (s)
         S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// 32-bit retired-instruction counter with increment enable and synchronous clear.
// Wraps naturally from 0xFFFFFFFF to 0.
module mc_retire_counter (
   input  logic        clk,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 32'd0;
      end else if (inc_i) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/memory/write-back sequencing.
// Define MC_CTRL_ADDI_EN to decode addi through ADDI_EXEC/ADDI_WB.
module mc_control_fsm
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  Opcode,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        IRWrite,
   output logic        ALUSrcA,
   output logic        RegWrite,
   output logic        RegDst,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic        IllegalOp,
   output logic [31:0] RetiredCount
);

   state_e state_q;
   state_e state_d;
   logic   retire_inc_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (MemReady) state_d = S_DECODE;
            else          state_d = S_FETCH;
         end
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
               OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            if (Opcode == OP_LW) state_d = S_MEM_READ;
            else                 state_d = S_MEM_WRITE;
         end
         S_MEM_READ: begin
            if (MemReady) state_d = S_MEM_WB;
            else          state_d = S_MEM_READ;
         end
         S_MEM_WRITE: begin
            if (MemReady) state_d = S_FETCH;
            else          state_d = S_MEM_WRITE;
         end
         S_EXECUTE: state_d = S_R_WB;
`ifdef MC_CTRL_ADDI_EN
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_ADDI_WB:   state_d = S_FETCH;
`endif
         default:     state_d = S_FETCH;
      endcase
   end

   // Outputs follow the current state; reset forces every control low.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUOp       = ALUOP_ADD;
      ALUSrcB     = SRCB_REGB;
      PCSource    = PCSRC_ALU;
      IllegalOp   = 1'b0;
      if (rst) begin
         IllegalOp = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_DECODE: begin
               ALUSrcB   = SRCB_IMM_SH;
               IllegalOp = ~op_supported(Opcode);
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_EXECUTE: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_ADDI_WB: begin
               RegWrite = 1'b1;
            end
`endif
            default: begin
               IllegalOp = 1'b0;
            end
         endcase
      end
   end

   // An illegal-opcode return leaves from DECODE, which is not a retiring state.
   assign retire_inc_s = ~rst & (state_d == S_FETCH) & is_retire_state(state_q);

   mc_retire_counter u_retire (
      .clk     (clk),
      .clr_i   (rst),
      .inc_i   (retire_inc_s),
      .count_o (RetiredCount)
   );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm against a per-instruction cycle model.
// Each instruction is expanded into its list of cycle phases from the opcode; stalls repeat a phase.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  Opcode;
   logic        MemReady;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic        IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
   logic [1:0]  ALUOp, ALUSrcB, PCSource;
   logic [31:0] RetiredCount;

   int n_cmp = 0;
   int n_err = 0;

   localparam int PH_F    = 0;
   localparam int PH_D    = 1;
   localparam int PH_DILL = 2;
   localparam int PH_MA   = 3;
   localparam int PH_MR   = 4;
   localparam int PH_MWB  = 5;
   localparam int PH_MW   = 6;
   localparam int PH_EX   = 7;
   localparam int PH_RWB  = 8;
   localparam int PH_BR   = 9;
   localparam int PH_J    = 10;
   localparam int PH_AE   = 11;
   localparam int PH_AW   = 12;

   int          ph_q[$];
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk          (clk),
      .rst          (rst),
      .Opcode       (Opcode),
      .MemReady     (MemReady),
      .PCWrite      (PCWrite),
      .PCWriteCond  (PCWriteCond),
      .IorD         (IorD),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .MemtoReg     (MemtoReg),
      .IRWrite      (IRWrite),
      .ALUSrcA      (ALUSrcA),
      .RegWrite     (RegWrite),
      .RegDst       (RegDst),
      .ALUOp        (ALUOp),
      .ALUSrcB      (ALUSrcB),
      .PCSource     (PCSource),
      .IllegalOp    (IllegalOp),
      .RetiredCount (RetiredCount)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_word();
      return {15'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
              ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, IllegalOp};
   endfunction

   // Control word the spec table lists for a phase (MemReady matters only in fetch).
   function automatic logic [31:0] exp_word(input int ph, input logic rdy);
      logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill;
      logic [1:0] aop, asb, pcs;
      {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill} = 11'd0;
      aop = 2'b00; asb = 2'b00; pcs = 2'b00;
      case (ph)
         PH_F:    begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
         PH_D:    begin asb = 2'b11; end
         PH_DILL: begin asb = 2'b11; ill = 1'b1; end
         PH_MA:   begin asa = 1'b1; asb = 2'b10; end
         PH_MR:   begin mr = 1'b1; iord = 1'b1; end
         PH_MWB:  begin rw = 1'b1; m2r = 1'b1; end
         PH_MW:   begin mw = 1'b1; iord = 1'b1; end
         PH_EX:   begin asa = 1'b1; aop = 2'b10; end
         PH_RWB:  begin rw = 1'b1; rd = 1'b1; end
         PH_BR:   begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
         PH_J:    begin pcw = 1'b1; pcs = 2'b10; end
         PH_AE:   begin asa = 1'b1; asb = 2'b10; end
         PH_AW:   begin rw = 1'b1; end
         default: begin ill = 1'b0; end
      endcase
      return {15'd0, pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, aop, asb, pcs, ill};
   endfunction

   // Returns 1 when the opcode is a real instruction that will retire.
   function automatic logic build_phases(input logic [5:0] op);
      logic legal;
      legal = 1'b1;
      ph_q.delete();
      ph_q.push_back(PH_F);
      case (op)
         6'b000000: begin ph_q.push_back(PH_D); ph_q.push_back(PH_EX); ph_q.push_back(PH_RWB); end
         6'b100011: begin ph_q.push_back(PH_D); ph_q.push_back(PH_MA); ph_q.push_back(PH_MR);
                          ph_q.push_back(PH_MWB); end
         6'b101011: begin ph_q.push_back(PH_D); ph_q.push_back(PH_MA); ph_q.push_back(PH_MW); end
         6'b000100: begin ph_q.push_back(PH_D); ph_q.push_back(PH_BR); end
         6'b000010: begin ph_q.push_back(PH_D); ph_q.push_back(PH_J); end
`ifdef MC_CTRL_ADDI_EN
         6'b001000: begin ph_q.push_back(PH_D); ph_q.push_back(PH_AE); ph_q.push_back(PH_AW); end
`endif
         default:   begin ph_q.push_back(PH_DILL); legal = 1'b0; end
      endcase
      return legal;
   endfunction

   // Runs one instruction starting at a negedge with the DUT in FETCH; ends at the
   // negedge of the following FETCH cycle. stall_pct is the chance MemReady is low.
   task automatic run_instr(input logic [5:0] op, input int stall_pct);
      logic legal;
      int   idx;
      int   stalls;
      logic rdy;
      legal  = build_phases(op);
      Opcode = op;
      idx    = 0;
      stalls = 0;
      while (idx < ph_q.size()) begin
         rdy = ($urandom_range(0, 99) >= stall_pct) || (stalls >= 6);
         MemReady = rdy;
         #1;
         check_eq("ctrl", obs_word(), exp_word(ph_q[idx], rdy));
         check_eq("count", RetiredCount, exp_cnt);
         if ((ph_q[idx] == PH_F || ph_q[idx] == PH_MR || ph_q[idx] == PH_MW) && !rdy) begin
            stalls++;
         end else begin
            stalls = 0;
            idx++;
         end
         @(negedge clk);
      end
      if (legal) exp_cnt = exp_cnt + 32'd1;
   endtask

   logic [5:0] op_tab[8];

   initial begin
      op_tab[0] = 6'b000000; op_tab[1] = 6'b100011; op_tab[2] = 6'b101011;
      op_tab[3] = 6'b000100; op_tab[4] = 6'b000010; op_tab[5] = 6'b001000;
      op_tab[6] = 6'b111111; op_tab[7] = 6'b000000;
      rst = 1'b1; Opcode = 6'b000000; MemReady = 1'b1;
      exp_cnt = 32'd0;

      // Reset: all controls low, counter cleared, even with MemReady high.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check_eq("rst_ctrl", obs_word(), 32'd0);
         check_eq("rst_count", RetiredCount, 32'd0);
      end
      rst = 1'b0;

      // Directed sequences from the plan.
      run_instr(6'b000000, 0);
      run_instr(6'b100011, 40);
      run_instr(6'b000100, 0);
      run_instr(6'b000010, 0);
      run_instr(6'b111111, 0);
      run_instr(6'b001000, 0);

      // Counter wrap: preload all-ones, retire one sw.
      force dut.u_retire.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_retire.count_q;
      exp_cnt = 32'hFFFF_FFFF;
      run_instr(6'b101011, 0);
      MemReady = 1'b0; #1;
      check_eq("wrap", RetiredCount, 32'd0);
      @(negedge clk);

      // Randomized instruction stream with random MemReady stalls.
      for (int n = 0; n < 300; n++) begin
         int k;
         logic [5:0] op;
         k = $urandom_range(0, 7);
         if (k == 7) op = 6'($urandom);
         else        op = op_tab[k];
         run_instr(op, 30);
      end

      // Reset asserted during a stalled MEM_WRITE abandons the store.
      Opcode = 6'b101011;
      MemReady = 1'b1; #1;
      check_eq("mw_fetch", obs_word(), exp_word(PH_F, 1'b1));
      @(negedge clk); #1;
      check_eq("mw_dec", obs_word(), exp_word(PH_D, 1'b1));
      @(negedge clk); #1;
      check_eq("mw_addr", obs_word(), exp_word(PH_MA, 1'b1));
      @(negedge clk);
      MemReady = 1'b0; #1;
      check_eq("mw_stall", obs_word(), exp_word(PH_MW, 1'b0));
      @(negedge clk);
      rst = 1'b1; MemReady = 1'b1; #1;
      check_eq("mw_rst_ctrl", obs_word(), 32'd0);
      @(negedge clk);
      rst = 1'b0; MemReady = 1'b0; #1;
      check_eq("mw_rst_fetch", obs_word(), exp_word(PH_F, 1'b0));
      check_eq("mw_rst_count", RetiredCount, 32'd0);
      exp_cnt = 32'd0;
      @(negedge clk);
      run_instr(6'b000000, 20);
      MemReady = 1'b0; #1;
      check_eq("post_rst_count", RetiredCount, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
